// File: rtl/tb_regbus_mem_pkg.sv
// Shared types and constants for the latency-modelled regbus memory.
package tb_regbus_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    localparam int unsigned LatCntWidth = 4;
    localparam int unsigned AccCntWidth = 32;

    // Default regbus request/response shapes (48-bit address, 32-bit data).
    typedef struct packed {
        logic [47:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        valid;
    } regbus_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } regbus_rsp_t;

endpackage

// File: rtl/tb_sat_counter.sv
// Saturating up-counter: sticks at all-ones, synchronous active-high reset.
module tb_sat_counter #(
    parameter int unsigned Width = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en,
    output logic [Width-1:0] q
);

    logic [Width-1:0] cnt_q;

    // Count enabled events until the counter is full, then hold.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (en && (cnt_q != '1)) begin
            cnt_q <= cnt_q + Width'(1);
        end
    end

    assign q = cnt_q;

endmodule

// File: rtl/tb_regbus_mem_lat.sv
// Regbus memory model with configurable response latency and saturating
// read/write access counters. Optional feature macro:
//   TB_REGBUS_MEM_OOR_ERR_EN - out-of-range accesses respond with error=1,
//   rdata=0 and drop writes; otherwise the word index wraps modulo NumWords.
module tb_regbus_mem_lat
    import tb_regbus_mem_pkg::*;
#(
    parameter int unsigned          AddrWidth = 48,
    parameter int unsigned          DataWidth = 32,
    parameter int unsigned          NumWords  = 1024,
    parameter logic [AddrWidth-1:0] BaseAddr  = '0,
    parameter int unsigned          Latency   = 2,
    parameter type                  req_t     = regbus_req_t,
    parameter type                  rsp_t     = regbus_rsp_t
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  req_t                   req_i,
    output rsp_t                   rsp_o,
    output logic                   busy_o,
    output logic [AccCntWidth-1:0] rd_cnt_o,
    output logic [AccCntWidth-1:0] wr_cnt_o
);

    localparam int unsigned StrbWidth = DataWidth / 8;
    localparam int unsigned OffBits   = $clog2(StrbWidth);
    localparam int unsigned IdxWidth  = (NumWords > 1) ? $clog2(NumWords) : 1;

    logic [DataWidth-1:0] mem [NumWords];

    state_e                 state_q, state_d;
    logic [LatCntWidth-1:0] lat_q, lat_d;
    logic                   latch_en;

    logic [IdxWidth-1:0]    idx_q;
    logic                   oor_q, write_q;
    logic [DataWidth-1:0]   wdata_q, rdata_q;
    logic [StrbWidth-1:0]   wstrb_q;

    // Decode of the incoming address: byte offset dropped, index wraps.
    logic [AddrWidth-1:0]   req_word;
    logic [IdxWidth-1:0]    req_idx;
    logic                   req_oor;

    assign req_word = (req_i.addr - BaseAddr) >> OffBits;
    assign req_oor  = (req_i.addr < BaseAddr) || (req_word >= AddrWidth'(NumWords));
    assign req_idx  = IdxWidth'(req_word % AddrWidth'(NumWords));

    // The access completing this cycle: live request for Latency 0, else latched.
    logic                   acc_done, acc_write, acc_oor;
    logic [IdxWidth-1:0]    acc_idx;
    logic [DataWidth-1:0]   acc_wdata;
    logic [StrbWidth-1:0]   acc_wstrb;

    // Read-data source when entering RESP (IDLE->RESP uses the live request).
    logic [IdxWidth-1:0]    rd_idx;
    logic                   rd_oor;
    logic                   oor_err, rd_err;

    assign rd_idx = (state_q == IDLE) ? req_idx : idx_q;
    assign rd_oor = (state_q == IDLE) ? req_oor : oor_q;

`ifdef TB_REGBUS_MEM_OOR_ERR_EN
    assign oor_err = acc_oor;
    assign rd_err  = rd_oor;
`else
    logic unused_oor;
    assign oor_err    = 1'b0;
    assign rd_err     = 1'b0;
    assign unused_oor = acc_oor ^ rd_oor;
`endif

    // Next-state logic: IDLE latches, WAIT counts down, RESP lasts one cycle.
    always_comb begin
        state_d  = state_q;
        lat_d    = lat_q;
        latch_en = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_i.valid && (Latency != 0)) begin
                    latch_en = 1'b1;
                    lat_d    = LatCntWidth'(Latency - 1);
                    state_d  = (Latency == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (!req_i.valid) begin
                    state_d = IDLE;
                end else begin
                    lat_d = lat_q - LatCntWidth'(1);
                    if (lat_d == '0) state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM state, latched request and registered read data.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            lat_q   <= '0;
            idx_q   <= '0;
            oor_q   <= 1'b0;
            write_q <= 1'b0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            if (latch_en) begin
                idx_q   <= req_idx;
                oor_q   <= req_oor;
                write_q <= req_i.write;
                wdata_q <= req_i.wdata;
                wstrb_q <= req_i.wstrb;
            end
            rdata_q <= ((state_d == RESP) && !rd_err) ? mem[rd_idx] : '0;
        end
    end

    // Select which access (live or latched) is finishing this cycle.
    always_comb begin
        acc_done  = (state_q == RESP);
        acc_write = write_q;
        acc_oor   = oor_q;
        acc_idx   = idx_q;
        acc_wdata = wdata_q;
        acc_wstrb = wstrb_q;
        if (Latency == 0) begin
            acc_done  = req_i.valid;
            acc_write = req_i.write;
            acc_oor   = req_oor;
            acc_idx   = req_idx;
            acc_wdata = req_i.wdata;
            acc_wstrb = req_i.wstrb;
        end
    end

    // Response is all-zero except during the ready cycle.
    always_comb begin
        rsp_o       = '0;
        rsp_o.ready = acc_done;
        rsp_o.error = acc_done && oor_err;
        if (Latency == 0) begin
            rsp_o.rdata = (acc_done && !oor_err) ? mem[req_idx] : '0;
        end else begin
            rsp_o.rdata = acc_done ? rdata_q : '0;
        end
    end

    // Memory clears on reset; writes commit at the edge ending the ready cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(NumWords); i++) mem[i] <= '0;
        end else if (acc_done && acc_write && !oor_err) begin
            for (int b = 0; b < int'(StrbWidth); b++) begin
                if (acc_wstrb[b]) mem[acc_idx][b*8 +: 8] <= acc_wdata[b*8 +: 8];
            end
        end
    end

    assign busy_o = (state_q == WAIT);

    tb_sat_counter #(.Width(AccCntWidth)) u_rd_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en    (acc_done && !acc_write),
        .q     (rd_cnt_o)
    );

    tb_sat_counter #(.Width(AccCntWidth)) u_wr_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en    (acc_done && acc_write),
        .q     (wr_cnt_o)
    );

    // Flag a master that abandons a request while it is still in flight.
    always @(posedge clk_i) begin
        if (!rst_i && (state_q == WAIT) && !req_i.valid)
            $error("tb_regbus_mem_lat: valid dropped during WAIT, access aborted");
    end

`ifdef TB_REGBUS_MEM_OOR_ERR_EN
    // Log every out-of-range access as it completes.
    always @(posedge clk_i) begin
        if (!rst_i && acc_done && acc_oor)
            $warning("tb_regbus_mem_lat: out-of-range access, index %0d", acc_idx);
    end
`endif

endmodule

// File: tb/tb_tb_regbus_mem_lat.sv
// Bench for tb_regbus_mem_lat: three instances (Latency 2, 0 and 3) checked
// against an associative-array memory model and saturating counter model.
module tb_tb_regbus_mem_lat;
    import tb_regbus_mem_pkg::*;

`ifdef TB_REGBUS_MEM_OOR_ERR_EN
    localparam bit ErrEn = 1'b1;
`else
    localparam bit ErrEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic [2:0]  rst;
    regbus_req_t req    [3];
    regbus_rsp_t rsp    [3];
    logic [2:0]  busy;
    logic [31:0] rd_cnt [3];
    logic [31:0] wr_cnt [3];

    always #5 clk = ~clk;

    tb_regbus_mem_lat #(.Latency(2)) u_l2 (
        .clk_i(clk), .rst_i(rst[0]), .req_i(req[0]), .rsp_o(rsp[0]),
        .busy_o(busy[0]), .rd_cnt_o(rd_cnt[0]), .wr_cnt_o(wr_cnt[0]));

    tb_regbus_mem_lat #(.Latency(0), .NumWords(64), .BaseAddr(48'h4000)) u_l0 (
        .clk_i(clk), .rst_i(rst[1]), .req_i(req[1]), .rsp_o(rsp[1]),
        .busy_o(busy[1]), .rd_cnt_o(rd_cnt[1]), .wr_cnt_o(wr_cnt[1]));

    tb_regbus_mem_lat #(.Latency(3), .NumWords(64), .BaseAddr(48'h4000)) u_l3 (
        .clk_i(clk), .rst_i(rst[2]), .req_i(req[2]), .rsp_o(rsp[2]),
        .busy_o(busy[2]), .rd_cnt_o(rd_cnt[2]), .wr_cnt_o(wr_cnt[2]));

    int checks = 0;
    int errors = 0;

    logic [31:0] mdl [int];
    longint      mrd [3];
    longint      mwr [3];

    function automatic int lat_of(input int s);
        return (s == 0) ? 2 : (s == 1) ? 0 : 3;
    endfunction

    function automatic logic [47:0] base_of(input int s);
        return (s == 0) ? 48'h0 : 48'h4000;
    endfunction

    function automatic int nw_of(input int s);
        return (s == 0) ? 1024 : 64;
    endfunction

    function automatic int key(input int s, input int idx);
        return s * 65536 + idx;
    endfunction

    function automatic longint sat(input longint v);
        return (v >= 64'hFFFF_FFFF) ? v : v + 1;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset(input int s);
        for (int i = 0; i < nw_of(s); i++) if (mdl.exists(key(s, i))) mdl.delete(key(s, i));
        mrd[s] = 0;
        mwr[s] = 0;
    endtask

    // One access, entered at a negedge; returns at the negedge after the
    // ready cycle with valid still high so the caller may chain another.
    task automatic access(input int s, input bit wr, input logic [47:0] addr,
                          input logic [31:0] wd, input logic [3:0] st, output logic [31:0] rd);
        logic [47:0] word;
        int          idx, c, k;
        bit          oor, done, exp_err;
        logic [31:0] old;
        word    = (addr - base_of(s)) / 4;
        oor     = (addr < base_of(s)) || (word >= 48'(nw_of(s)));
        idx     = int'(word % 48'(nw_of(s)));
        k       = key(s, idx);
        old     = mdl.exists(k) ? mdl[k] : 32'h0;
        exp_err = oor && ErrEn;
        req[s]  = '{addr: addr, write: wr, wdata: wd, wstrb: st, valid: 1'b1};
        c = 0;
        done = 1'b0;
        while (!done && c <= 20) begin
            #1;
            if (rsp[s].ready) done = 1'b1;
            else begin
                chk($sformatf("busy%0d_c%0d", s, c), 64'(busy[s]), 64'(c > 0));
                @(negedge clk);
                c++;
            end
        end
        chk($sformatf("lat%0d", s), 64'(c), 64'(lat_of(s)));
        rd = 32'h0;
        if (done) begin
            rd = rsp[s].rdata;
            chk($sformatf("err%0d", s), 64'(rsp[s].error), 64'(exp_err));
            if (!wr) chk($sformatf("rdata%0d", s), 64'(rsp[s].rdata), 64'(exp_err ? 32'h0 : old));
        end
        if (wr && !exp_err) begin
            for (int b = 0; b < 4; b++) if (st[b]) old[b*8 +: 8] = wd[b*8 +: 8];
            mdl[k] = old;
        end
        if (wr) mwr[s] = sat(mwr[s]);
        else    mrd[s] = sat(mrd[s]);
        @(negedge clk);
        chk($sformatf("rd_cnt%0d", s), 64'(rd_cnt[s]), 64'(mrd[s]));
        chk($sformatf("wr_cnt%0d", s), 64'(wr_cnt[s]), 64'(mwr[s]));
    endtask

    task automatic idle(input int s);
        req[s].valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] rd;
        logic [47:0] a;
        int          w;
        for (int s = 0; s < 3; s++) begin
            req[s] = '0;
            model_reset(s);
        end
        rst = 3'b111;
        repeat (3) @(negedge clk);
        rst = 3'b000;
        #1;
        for (int s = 0; s < 3; s++) begin
            chk($sformatf("rst_ready%0d", s), 64'(rsp[s].ready), 64'h0);
            chk($sformatf("rst_error%0d", s), 64'(rsp[s].error), 64'h0);
            chk($sformatf("rst_rdata%0d", s), 64'(rsp[s].rdata), 64'h0);
            chk($sformatf("rst_busy%0d", s), 64'(busy[s]), 64'h0);
            chk($sformatf("rst_rdcnt%0d", s), 64'(rd_cnt[s]), 64'h0);
            chk($sformatf("rst_wrcnt%0d", s), 64'(wr_cnt[s]), 64'h0);
        end
        @(negedge clk);

        // Latency 2: full-word write then read back.
        access(0, 1'b1, 48'h10, 32'hDEAD_BEEF, 4'hF, rd);
        idle(0);
        access(0, 1'b0, 48'h10, 32'h0, 4'h0, rd);
        chk("rb_deadbeef", 64'(rd), 64'hDEAD_BEEF);
        chk("rb_rdcnt", 64'(rd_cnt[0]), 64'h1);
        chk("rb_wrcnt", 64'(wr_cnt[0]), 64'h1);
        idle(0);

        // Byte-lane merge, and wstrb=0 leaves the word unchanged.
        access(0, 1'b1, 48'h20, 32'h1122_3344, 4'hF, rd);
        access(0, 1'b1, 48'h21, 32'h0000_00AA, 4'h1, rd);
        access(0, 1'b0, 48'h20, 32'h0, 4'h0, rd);
        chk("strb_merge", 64'(rd), 64'h1122_33AA);
        access(0, 1'b1, 48'h20, 32'hFFFF_FFFF, 4'h0, rd);
        access(0, 1'b0, 48'h20, 32'h0, 4'h0, rd);
        chk("strb_zero", 64'(rd), 64'h1122_33AA);
        idle(0);

        // Latency 0: write then read on consecutive cycles.
        access(1, 1'b1, 48'h4008, 32'hCAFE_F00D, 4'hF, rd);
        access(1, 1'b0, 48'h4008, 32'h0, 4'h0, rd);
        chk("l0_rb", 64'(rd), 64'hCAFE_F00D);
        idle(1);

        // Out-of-range read one word past the end.
        access(0, 1'b1, 48'h0, 32'h0BAD_C0DE, 4'hF, rd);
        access(0, 1'b0, 48'h1000, 32'h0, 4'h0, rd);
        chk("oor_rdata", 64'(rd), ErrEn ? 64'h0 : 64'h0BAD_C0DE);
        idle(0);
        access(1, 1'b1, 48'h3FFC, 32'h7777_1234, 4'hF, rd);
        access(1, 1'b0, 48'h40FC, 32'h0, 4'h0, rd);
        idle(1);

        // Reset during cycle 1 of a Latency 3 write aborts it.
        access(2, 1'b1, 48'h4004, 32'h1234_5678, 4'hF, rd);
        idle(2);
        req[2] = '{addr: 48'h4030, write: 1'b1, wdata: 32'h5555_AAAA, wstrb: 4'hF, valid: 1'b1};
        @(negedge clk);
        #1 chk("abort_busy_pre", 64'(busy[2]), 64'h1);
        rst[2] = 1'b1;
        @(negedge clk);
        rst[2] = 1'b0;
        req[2].valid = 1'b0;
        model_reset(2);
        #1;
        chk("abort_busy", 64'(busy[2]), 64'h0);
        chk("abort_rdcnt", 64'(rd_cnt[2]), 64'h0);
        chk("abort_wrcnt", 64'(wr_cnt[2]), 64'h0);
        @(negedge clk);
        access(2, 1'b0, 48'h4030, 32'h0, 4'h0, rd);
        chk("abort_rd", 64'(rd), 64'h0);
        idle(2);

        // Randomised back-to-back traffic on Latency 2 and Latency 0.
        for (int s = 0; s < 2; s++) begin
            for (int n = 0; n < 30; n++) begin
                w = ($urandom_range(0, 7) == 0) ? nw_of(s) + int'($urandom_range(0, 3))
                                                : int'($urandom_range(0, 15));
                a = base_of(s) + 48'(w) * 4 + 48'($urandom_range(0, 3));
                if (s == 1 && $urandom_range(0, 15) == 0) a = base_of(s) - 48'h4;
                access(s, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), rd);
            end
            idle(s);
        end

        // Read counter saturation.
        force u_l2.u_rd_cnt.cnt_q = 32'hFFFF_FFFE;
        #1 release u_l2.u_rd_cnt.cnt_q;
        @(negedge clk);
        chk("sat_preload", 64'(rd_cnt[0]), 64'hFFFF_FFFE);
        mrd[0] = 64'hFFFF_FFFE;
        for (int n = 0; n < 3; n++) access(0, 1'b0, 48'h10, 32'h0, 4'h0, rd);
        idle(0);
        chk("sat_hold", 64'(rd_cnt[0]), 64'hFFFF_FFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
